note_mem_reader: RTL and testbench

//  Playback-side reader of the note memory the CPU writes through mem_interface (n_mem).
//  On start, walks note words from base_addr through the memory read port and decodes each word.

---
 rtl/note_mem_reader_if.sv | 22 ++
 rtl/note_mem_reader.sv | 167 ++++++++++++++++
 tb/tb_note_mem_reader.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/note_mem_reader_if.sv
// Synth-side note channel of the note memory reader: offered pitch, valid/ready
// handshake and the sounding flag.
interface note_mem_reader_if;
  logic [6:0] note_pitch;
  logic       note_valid;
  logic       note_ready;
  logic       note_on;

  modport master (
    output note_pitch,
    output note_valid,
    output note_on,
    input  note_ready
  );

  modport slave (
    input  note_pitch,
    input  note_valid,
    input  note_on,
    output note_ready
  );
endinterface

// File: rtl/note_mem_reader.sv
// Playback reader: walks note words from base_addr, offers each to the synth, then
// holds it for its tick duration. Optional looping via NOTE_READER_LOOP_EN.
module note_mem_reader #(
  parameter int ADDR_W   = 11,
  parameter int DEPTH    = 1024,
  parameter int TICK_DIV = 50000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic [ADDR_W-1:0] base_addr,
  output logic [ADDR_W-1:0] read_addr,
  input  logic [15:0]       rd_data,
  note_mem_reader_if.master note,
  output logic              busy,
  output logic              done
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_PRESENT,
    S_PLAY
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] ra_q, ra_d;
  logic [6:0]        pitch_q, pitch_d;
  logic [7:0]        dur_q, dur_d;
  logic              valid_q, valid_d;
  logic              on_q, on_d;
  logic              done_q, done_d;
  logic [PW-1:0]     presc_q, presc_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [7:0]        cnt_inc;
  logic [ADDR_W-1:0] ptr_next;
`ifdef NOTE_READER_LOOP_EN
  logic [ADDR_W-1:0] base_q, base_d;
`endif

  // An 8-bit counter wrapping to 0 after 256 ticks matches a duration field of 0.
  assign cnt_inc  = cnt_q + 8'd1;
  assign ptr_next = (ptr_q == LAST_ADDR) ? '0 : ptr_q + ADDR_W'(1);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    ra_d    = ra_q;
    pitch_d = pitch_q;
    dur_d   = dur_q;
    valid_d = valid_q;
    on_d    = on_q;
    done_d  = 1'b0;
    presc_d = presc_q;
    cnt_d   = cnt_q;
`ifdef NOTE_READER_LOOP_EN
    base_d  = base_q;
`endif
    if (stop) begin
      state_d = S_IDLE;
      valid_d = 1'b0;
      on_d    = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d = S_FETCH;
            ptr_d   = base_addr;
`ifdef NOTE_READER_LOOP_EN
            base_d  = base_addr;
`endif
          end
        end
        S_FETCH: begin
          ra_d    = ptr_q;
          state_d = S_WAIT;
        end
        S_WAIT: begin
          if (rd_data[15]) begin
            done_d = 1'b1;
`ifdef NOTE_READER_LOOP_EN
            ptr_d   = base_q;
            state_d = S_FETCH;
`else
            state_d = S_IDLE;
`endif
          end else begin
            pitch_d = rd_data[14:8];
            dur_d   = rd_data[7:0];
            valid_d = 1'b1;
            state_d = S_PRESENT;
          end
        end
        S_PRESENT: begin
          if (note.note_ready) begin
            valid_d = 1'b0;
            on_d    = (pitch_q != '0);
            presc_d = '0;
            cnt_d   = '0;
            state_d = S_PLAY;
          end
        end
        S_PLAY: begin
          if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            cnt_d   = cnt_inc;
            if (cnt_inc == dur_q) begin
              on_d    = 1'b0;
              ptr_d   = ptr_next;
              state_d = S_FETCH;
            end
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      ra_q    <= '0;
      pitch_q <= '0;
      dur_q   <= '0;
      valid_q <= 1'b0;
      on_q    <= 1'b0;
      done_q  <= 1'b0;
      presc_q <= '0;
      cnt_q   <= '0;
`ifdef NOTE_READER_LOOP_EN
      base_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      ra_q    <= ra_d;
      pitch_q <= pitch_d;
      dur_q   <= dur_d;
      valid_q <= valid_d;
      on_q    <= on_d;
      done_q  <= done_d;
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
`ifdef NOTE_READER_LOOP_EN
      base_q  <= base_d;
`endif
    end
  end

  assign read_addr       = ra_q;
  assign note.note_pitch = pitch_q;
  assign note.note_valid = valid_q;
  assign note.note_on    = on_q;
  assign busy            = (state_q != S_IDLE);
  assign done            = done_q;

endmodule

// File: tb/tb_note_mem_reader.sv
// Bench for note_mem_reader: a timeline model of each song (cycle arithmetic over the
// note words) is compared cycle by cycle against the reader, plus stop/reset scenarios.
module tb_note_mem_reader;
  localparam int AW    = 11;
  localparam int DEPTH = 1024;
  localparam int TD    = 4;

  logic          clk, rst, start, stop;
  logic [AW-1:0] base_addr, read_addr;
  logic [15:0]   rd_data;
  logic          busy, done;
  logic [15:0]   mem [0:2047];

  int checks = 0;
  int errors = 0;

  note_mem_reader_if nif ();

  note_mem_reader #(.ADDR_W(AW), .DEPTH(DEPTH), .TICK_DIV(TD)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .base_addr (base_addr),
    .read_addr (read_addr),
    .rd_data   (rd_data),
    .note      (nif),
    .busy      (busy),
    .done      (done)
  );

  assign rd_data = mem[read_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Song timeline, in cycles relative to the start cycle (cycle 0).
  int         m_pstart[$], m_pxfer[$], m_onend[$], m_wcyc[$], m_waddr[$], m_done[$];
  logic [6:0] m_pitch[$];
  bit         m_sounds[$];
  int         m_end, m_stop_cyc;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic build_model(input int base, input int npass, input int dmin, input int dmax);
    int t, addr, pass, d, dur, p;
    logic [15:0] w;
    m_pstart.delete(); m_pxfer.delete(); m_onend.delete();
    m_wcyc.delete(); m_waddr.delete(); m_done.delete();
    m_pitch.delete(); m_sounds.delete();
    t = 1; addr = base; pass = 0; m_end = -1; m_stop_cyc = -1;
    for (int n = 0; n < 256; n++) begin
      m_wcyc.push_back(t + 1);
      m_waddr.push_back(addr);
      w = mem[addr];
      if (w[15]) begin
        m_done.push_back(t + 2);
        pass++;
        if (pass == npass) begin
`ifdef NOTE_READER_LOOP_EN
          m_stop_cyc = t + 2;
          m_end      = t + 3;
`else
          m_end      = t + 2;
`endif
          break;
        end
        addr = base;
        t    = t + 2;
      end else begin
        p   = t + 2;
        d   = int'($urandom_range(dmax, dmin));
        dur = (w[7:0] == 8'd0) ? 256 : int'(w[7:0]);
        m_pstart.push_back(p);
        m_pxfer.push_back(p + d);
        m_onend.push_back(p + d + dur * TD);
        m_pitch.push_back(w[14:8]);
        m_sounds.push_back(w[14:8] != 7'd0);
        t    = p + d + 1 + dur * TD;
        addr = (addr + 1) % DEPTH;
      end
    end
    if (m_end < 0) begin
      $display("FAIL model: no end marker found from base %0d", base);
      $fatal(1);
    end
  endtask

  task automatic run_song(input int base, input int npass, input int dmin, input int dmax,
                          input string name);
    bit   bad;
    bit   e_busy, e_done, e_valid, e_on, rdy;
    logic [6:0] e_pitch;
    int   ra;
    bad = 1'b0;
    build_model(base, npass, dmin, dmax);
    base_addr = AW'(base);
    start = 1'b1; stop = 1'b0; nif.note_ready = 1'b0;
    for (int c = 1; c <= m_end && !bad; c++) begin
      step();
      start     = (c < m_end) ? 1'($urandom_range(1, 0)) : 1'b0;
      base_addr = AW'($urandom);
      stop      = (c == m_stop_cyc);
      rdy       = 1'($urandom_range(1, 0));
      e_busy = (c < m_end);
      e_done = 1'b0;
      foreach (m_done[k]) if (m_done[k] == c) e_done = 1'b1;
      e_valid = 1'b0; e_on = 1'b0; e_pitch = '0;
      foreach (m_pstart[k]) begin
        if (c >= m_pstart[k] && c <= m_pxfer[k]) begin
          e_valid = 1'b1;
          e_pitch = m_pitch[k];
        end
        if (c >= m_pstart[k] && c < m_pxfer[k]) rdy = 1'b0;
        if (c == m_pxfer[k]) rdy = 1'b1;
        if (m_sounds[k] && c > m_pxfer[k] && c <= m_onend[k]) e_on = 1'b1;
      end
      nif.note_ready = rdy;
      ra = -1;
      foreach (m_wcyc[k]) if (m_wcyc[k] <= c) ra = m_waddr[k];

      checks++;
      if (busy !== e_busy) begin
        errors++; bad = 1'b1;
        $display("FAIL %s busy cyc %0d got %b exp %b", name, c, busy, e_busy);
      end
      checks++;
      if (done !== e_done) begin
        errors++; bad = 1'b1;
        $display("FAIL %s done cyc %0d got %b exp %b", name, c, done, e_done);
      end
      checks++;
      if (nif.note_valid !== e_valid) begin
        errors++; bad = 1'b1;
        $display("FAIL %s note_valid cyc %0d got %b exp %b", name, c, nif.note_valid, e_valid);
      end
      checks++;
      if (nif.note_on !== e_on) begin
        errors++; bad = 1'b1;
        $display("FAIL %s note_on cyc %0d got %b exp %b", name, c, nif.note_on, e_on);
      end
      if (e_valid) begin
        checks++;
        if (nif.note_pitch !== e_pitch) begin
          errors++; bad = 1'b1;
          $display("FAIL %s note_pitch cyc %0d got %h exp %h", name, c, nif.note_pitch, e_pitch);
        end
      end
      if (ra >= 0) begin
        checks++;
        if (read_addr !== AW'(ra)) begin
          errors++; bad = 1'b1;
          $display("FAIL %s read_addr cyc %0d got %0d exp %0d", name, c, read_addr, ra);
        end
      end
    end
    start = 1'b0; stop = 1'b0; nif.note_ready = 1'b0;
    if (bad) step();
    if (bad) begin
      stop = 1'b1;
      step();
      stop = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    checks++;
    if ({read_addr, nif.note_pitch, nif.note_valid, nif.note_on, busy, done} !== '0) begin
      errors++;
      $display("FAIL reset outputs got ra=%0d p=%h v=%b on=%b busy=%b done=%b exp all 0",
               read_addr, nif.note_pitch, nif.note_valid, nif.note_on, busy, done);
    end
    rst = 1'b0;
  endtask

  task automatic test_example();
    mem[5] = 16'h3C03; mem[6] = 16'h8000;
    run_song(5, 1, 0, 0, "example");
  endtask

  task automatic test_ready_wait();
    mem[20] = 16'h4502; mem[21] = 16'h8000;
    run_song(20, 1, 10, 10, "ready_wait");
  endtask

  task automatic test_wrap();
    mem[DEPTH-1] = 16'h4001; mem[0] = 16'h8000;
    run_song(DEPTH - 1, 1, 0, 1, "wrap");
  endtask

  task automatic test_dur0_rest();
    mem[40] = 16'h4100; mem[41] = 16'h0003; mem[42] = 16'h8000;
    run_song(40, 1, 0, 2, "dur0_rest");
  endtask

  task automatic test_random();
    int base, n, addr;
    logic [6:0] p;
    for (int it = 0; it < 6; it++) begin
      base = int'($urandom_range(DEPTH - 1, 0));
      n    = int'($urandom_range(4, 1));
      for (int i = 0; i < n; i++) begin
        addr = (base + i) % DEPTH;
        p    = ($urandom_range(3, 0) == 0) ? 7'd0 : 7'($urandom_range(127, 1));
        mem[addr] = {1'b0, p, 8'($urandom_range(3, 1))};
      end
      mem[(base + n) % DEPTH] = 16'h8000 | 16'($urandom_range(16'h7FFF, 0));
      run_song(base, 1, 0, 3, "random");
    end
  endtask

  task automatic test_stop();
    mem[5] = 16'h3C03; mem[6] = 16'h8000;
    // stop while the note is being offered
    base_addr = 11'd5; start = 1'b1;
    step(); start = 1'b0;
    step();
    step(); nif.note_ready = 1'b0;
    checks++;
    if (nif.note_valid !== 1'b1) begin
      errors++; $display("FAIL stop_present valid_before got %b exp 1", nif.note_valid);
    end
    stop = 1'b1;
    step(); stop = 1'b0;
    checks++;
    if ({busy, nif.note_valid, nif.note_on, done} !== 4'b0000) begin
      errors++;
      $display("FAIL stop_present outputs got busy=%b v=%b on=%b done=%b exp 0000",
               busy, nif.note_valid, nif.note_on, done);
    end
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if ({busy, done} !== 2'b00) begin
        errors++; $display("FAIL stop_present idle got busy=%b done=%b exp 00", busy, done);
      end
    end
    // stop while the note is sounding
    base_addr = 11'd5; start = 1'b1;
    step(); start = 1'b0;
    step();
    step(); nif.note_ready = 1'b1;
    step(); nif.note_ready = 1'b0;
    checks++;
    if (nif.note_on !== 1'b1) begin
      errors++; $display("FAIL stop_play on_before got %b exp 1", nif.note_on);
    end
    step(); stop = 1'b1;
    step(); stop = 1'b0;
    checks++;
    if ({busy, nif.note_valid, nif.note_on, done} !== 4'b0000) begin
      errors++;
      $display("FAIL stop_play outputs got busy=%b v=%b on=%b done=%b exp 0000",
               busy, nif.note_valid, nif.note_on, done);
    end
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if ({busy, done} !== 2'b00) begin
        errors++; $display("FAIL stop_play idle got busy=%b done=%b exp 00", busy, done);
      end
    end
  endtask

  task automatic test_start_stop();
    base_addr = 11'd5; start = 1'b1; stop = 1'b1;
    step(); start = 1'b0; stop = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({busy, nif.note_valid, done} !== 3'b000) begin
        errors++;
        $display("FAIL start_stop idle got busy=%b v=%b done=%b exp 000", busy, nif.note_valid, done);
      end
      step();
    end
  endtask

  task automatic test_rst_mid_play();
    mem[5] = 16'h3C03; mem[6] = 16'h8000;
    base_addr = 11'd5; start = 1'b1;
    step(); start = 1'b0;
    step();
    step(); nif.note_ready = 1'b1;
    step(); nif.note_ready = 1'b0;
    checks++;
    if (nif.note_on !== 1'b1) begin
      errors++; $display("FAIL rst_mid on_before got %b exp 1", nif.note_on);
    end
    step(); rst = 1'b1;
    step(); rst = 1'b0;
    checks++;
    if ({read_addr, nif.note_pitch, nif.note_valid, nif.note_on, busy, done} !== '0) begin
      errors++;
      $display("FAIL rst_mid outputs got ra=%0d p=%h v=%b on=%b busy=%b done=%b exp all 0",
               read_addr, nif.note_pitch, nif.note_valid, nif.note_on, busy, done);
    end
    run_song(5, 1, 0, 1, "rst_replay");
  endtask

`ifdef NOTE_READER_LOOP_EN
  task automatic test_loop();
    mem[60] = 16'h3001; mem[61] = 16'h0002; mem[62] = 16'h8000;
    run_song(60, 3, 0, 1, "loop");
  endtask
`endif

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; base_addr = '0; nif.note_ready = 1'b0;
    for (int i = 0; i < 2048; i++) mem[i] = 16'h8000;
    test_reset();
    test_example();
    test_ready_wait();
    test_wrap();
    test_dur0_rest();
    test_random();
    test_stop();
    test_start_stop();
    test_rst_mid_play();
`ifdef NOTE_READER_LOOP_EN
    test_loop();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
